// File: rtl/panda_sc_imem_pkg.sv
// Shared types and constants for the Panda single-cycle instruction memory.
package panda_sc_imem_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Requested load length limited to the memory depth; 17 bits so Depth=65536 fits.
  function automatic logic [16:0] clamp_len(input logic [15:0] req, input logic [16:0] depth);
    logic [16:0] req_w;
    req_w = {1'b0, req};
    return (req_w > depth) ? depth : req_w;
  endfunction

endpackage

// File: rtl/panda_sc_imem_if.sv
// Fetch port and program-load byte stream between the core/boot source and the imem.
interface panda_sc_imem_if;

  logic [31:0] instr_addr_i;
  logic [31:0] instr_o;
  logic        instr_err_o;
  logic        load_start_i;
  logic [15:0] load_len_i;
  logic [7:0]  load_data_i;
  logic        load_valid_i;
  logic        load_ready_o;
  logic        load_done_o;

  modport master (
    output instr_addr_i, load_start_i, load_len_i, load_data_i, load_valid_i,
    input  instr_o, instr_err_o, load_ready_o, load_done_o
  );

  modport slave (
    input  instr_addr_i, load_start_i, load_len_i, load_data_i, load_valid_i,
    output instr_o, instr_err_o, load_ready_o, load_done_o
  );

endinterface

// File: rtl/panda_sc_imem_ram.sv
// Depth x 32 storage: combinational read, single synchronous write, contents survive reset.
module panda_sc_imem_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/panda_sc_imem.sv
// Instruction memory with byte-stream program loader; holds the core in reset while loading.
module panda_sc_imem
  import panda_sc_imem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  panda_sc_imem_if.slave  bus,
  output logic            core_rst_no
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  imem_state_e   state_q;
  logic [16:0]   len_q;
  logic [AW-1:0] waddr_q;
  logic [1:0]    byte_cnt_q;
  logic          ready_q;
  logic          done_q;
  logic          core_rst_nq;

  logic          accept;
  logic          word_done;
  logic          last_word;
  logic [23:0]   asm_w;
  logic [31:0]   wdata;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;
  logic          fetch_err;

  assign accept    = ready_q & bus.load_valid_i;
  assign word_done = accept & (byte_cnt_q == 2'd3);
  assign last_word = ({{(17 - AW){1'b0}}, waddr_q} == (len_q - 17'd1));

  // Bytes 0..2 park in their own lanes; byte 3 goes straight to the RAM with them.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [7:0] lane_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lane_q <= '0;
      end else if (accept && (byte_cnt_q == 2'(gi))) begin
        lane_q <= bus.load_data_i;
      end
    end

    assign asm_w[gi*8 +: 8] = lane_q;
  end

  assign wdata = {bus.load_data_i, asm_w};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= HALT;
      len_q       <= '0;
      waddr_q     <= '0;
      byte_cnt_q  <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      core_rst_nq <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        HALT, RUN: begin
          if (bus.load_start_i) begin
            if (bus.load_len_i == 16'd0) begin
              state_q     <= RUN;
              core_rst_nq <= 1'b1;
            end else begin
              state_q     <= LOAD;
              len_q       <= clamp_len(bus.load_len_i, DEPTH_L);
              waddr_q     <= '0;
              byte_cnt_q  <= '0;
              ready_q     <= 1'b1;
              core_rst_nq <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (word_done) begin
              waddr_q <= waddr_q + AW'(1);
              if (last_word) begin
                state_q     <= RUN;
                ready_q     <= 1'b0;
                done_q      <= 1'b1;
                core_rst_nq <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q     <= HALT;
          ready_q     <= 1'b0;
          core_rst_nq <= 1'b0;
        end
      endcase
    end
  end

  assign raddr     = bus.instr_addr_i[AW+1:2];
  assign fetch_err = (|bus.instr_addr_i[1:0]) | (|bus.instr_addr_i[31:AW+2]);

  panda_sc_imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (word_done),
    .waddr_i (waddr_q),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign bus.instr_o      = fetch_err ? INSTR_NOP : rdata;
  assign bus.instr_err_o  = fetch_err;
  assign bus.load_ready_o = ready_q;
  assign bus.load_done_o  = done_q;
  assign core_rst_no      = core_rst_nq;

endmodule

// File: doc/panda_sc_imem.md
# panda_sc_imem

Instruction memory responder for the single-cycle Panda core: it answers the controller's PC-addressed instruction fetch with a combinational read and owns the program-load path. Programs arrive as a little-endian byte stream over a valid/ready handshake, are packed into 32-bit words, and are written sequentially from word 0. A small state machine holds the core in reset while loading and releases it once the last word is written. It sits between the controller's fetch port and the external boot/debug byte source.

## Interface
- Depth, 1024, instruction words stored; power of two, 4 to 65536
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- instr_addr_i  in  32  byte fetch address (core PC)
- instr_o  out  32  fetched instruction, combinational
- instr_err_o  out  1  fetch address misaligned or beyond Depth
- load_start_i  in  1  begin a load; samples load_len_i
- load_len_i  in  16  number of words to load; 0 means run without loading
- load_data_i  in  8  program byte
- load_valid_i  in  1  byte valid
- load_ready_o  out  1  byte accepted when valid and ready are both high
- load_done_o  out  1  one-cycle pulse when a load completes
- core_rst_no  out  1  active-low reset for the core, registered

## Operation
- States (shared enum): HALT, LOAD, RUN. Reset: HALT, core_rst_no=0, load_ready_o=0, load_done_o=0, byte and word counters 0.
- HALT/RUN + load_start_i:
  - If load_len_i=0: go to RUN (from HALT) or stay in RUN.
  - Otherwise: go to LOAD, latch len = min(load_len_i, Depth), clear counters, drive core_rst_no=0.
- LOAD:
  - load_ready_o=1.
  - Each accepted byte shifts into the word assembler; byte k of a word lands in bits [8k+7:8k].
  - On the 4th byte, the assembled word is written to mem[waddr] and waddr increments.
  - When the written word is waddr=len-1: go to RUN, pulse load_done_o, set core_rst_no=1.
  - load_start_i is ignored while in LOAD.
- RUN: core_rst_no=1 and load_ready_o=0. Bytes offered are not accepted.
- Fetch, in every state:
  - Word index = instr_addr_i[AW+1:2], with AW = log2(Depth).
  - If instr_addr_i[1:0]≠0 or instr_addr_i ≥ 4·Depth: instr_o=32'h0000_0013 (NOP) and instr_err_o=1.
  - Otherwise: instr_o=mem[index] and instr_err_o=0.
- Memory contents are not cleared by reset. Words beyond the loaded length keep their old contents.
- Reset mid-load: the partial word is discarded. Words already written remain. The state machine returns to HALT.

## Timing
- Read latency 0: instr_o follows instr_addr_i combinationally.
- A write occurs at the clock edge that accepts the 4th byte. The new value is visible on instr_o from the next cycle.
- Back-to-back bytes: one byte per cycle at full rate. A word takes 4 accepted bytes; stalls (load_valid_i low) are allowed anywhere.
- load_done_o and the rise of core_rst_no occur in the cycle after the final byte is accepted.
- When load_start_i is sampled in RUN, core_rst_no falls in the next cycle. load_ready_o rises in that same cycle.

## Structure
- panda_pkg gains:
  - imem_state_e {HALT, LOAD, RUN}
  - constant INSTR_NOP = 32'h0000_0013
- Sub-module panda_sc_imem_ram: Depth×32, asynchronous read, synchronous single write port, no reset.
- The top level holds the state machine, the byte/word counters and the assembler.

## Test plan
- Reset released, no load: core_rst_no=0. Fetch 0x0 returns memory contents and instr_err_o=0. Fetch 0x2 returns 0x00000013 with instr_err_o=1.
- load_start_i with load_len_i=2, bytes 93,00,10,00,13,01,20,00 at full rate: mem[0]=0x00100093 and mem[1]=0x00200113. load_done_o pulses once, and core_rst_no=1 the cycle after the 8th byte.
- Same load with load_valid_i toggling every other cycle: identical memory result. Done arrives after 8 acceptances, not 8 cycles.
- load_len_i=0xFFFF with Depth=4: exactly 16 bytes are accepted, then RUN. Fetch 0x10 gives NOP with instr_err_o=1.
- In RUN, load_start_i with len=1: core_rst_no goes low the next cycle, 4 bytes rewrite mem[0], and mem[1] is unchanged.
- rst_ni asserted after 6 of 8 bytes: HALT, mem[0] written, mem[1] unchanged, load_ready_o=0.
